// File: rtl/pad_event_frontend.sv
// Pad/button input front-end: per-channel sync, polarity fix and debounce,
// plus a rotating arbiter that queues press/release events into a small FIFO.
module pad_event_frontend #(
   parameter int                  CHANNELS        = 24,
   parameter int                  DEBOUNCE_CYCLES = 16,
   parameter logic [CHANNELS-1:0] INVERT_MASK     = '0,
   parameter int                  FIFO_DEPTH      = 8,
   parameter int                  CW              = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                        clock,
   input  logic                        resetn,
   input  logic [CHANNELS-1:0]         raw_in,
   input  logic [CHANNELS-1:0]         chan_enable,
   output logic [CHANNELS-1:0]         level_out,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [CW-1:0]               evt_chan,
   output logic                        evt_rise,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   input  logic                        clr_overflow
);

   localparam int                CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam int                AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]       DEPTH_C = (AW + 1)'(FIFO_DEPTH);

   logic [CHANNELS-1:0] r_sync1, r_sync2, r_st, r_pend, r_dir;
   logic [CNT_W-1:0]    r_cnt [CHANNELS];
   logic [CW-1:0]       r_ptr;
   logic                r_overflow;
   logic [CW:0]         r_mem [FIFO_DEPTH];
   logic [AW-1:0]       r_rd_ptr, r_wr_ptr;
   logic [AW:0]         r_count;

   logic [CHANNELS-1:0] w_s, w_st_next, w_capture, w_req, w_clear, w_overwrite;
   logic                w_grant, w_push, w_pop;
   logic [CW-1:0]       w_gnt_idx;
   logic [CW:0]         w_head;

   assign w_s = r_sync2 ^ INVERT_MASK;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         w_st_next[i] = (w_s[i] != r_st[i] && r_cnt[i] == CNT_MAX) ? w_s[i] : r_st[i];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_st    <= '0;
         for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= raw_in;
         r_sync2 <= r_sync1;
         r_st    <= w_st_next;
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_s[i] != r_st[i] && r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            else                                          r_cnt[i] <= '0;
         end
      end
   end

   assign w_capture = (w_st_next ^ r_st) & chan_enable;
   assign w_req     = r_pend & chan_enable;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      logic [CW:0] sum;
      w_grant   = 1'b0;
      w_gnt_idx = '0;
      sum       = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         sum = {1'b0, r_ptr} + (CW + 1)'(k);
         if (sum >= (CW + 1)'(CHANNELS)) sum = sum - (CW + 1)'(CHANNELS);
         if (!w_grant && w_req[sum[CW-1:0]]) begin
            w_grant   = 1'b1;
            w_gnt_idx = sum[CW-1:0];
         end
      end
   end

   assign w_pop  = (r_count != '0) && evt_ready;
   assign w_push = w_grant && ((r_count < DEPTH_C) || w_pop);

   always_comb begin
      w_clear            = '0;
      w_clear[w_gnt_idx] = w_push;
   end

   // A capture on the channel being granted this edge is not a lost event.
   assign w_overwrite = w_capture & r_pend & ~w_clear;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_pend     <= '0;
         r_dir      <= '0;
         r_ptr      <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_ptr <= (w_gnt_idx == CW'(CHANNELS - 1)) ? '0 : w_gnt_idx + CW'(1);
         if (|w_overwrite)     r_overflow <= 1'b1;
         else if (clr_overflow) r_overflow <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            if (!chan_enable[i]) begin
               r_pend[i] <= 1'b0;
            end else if (w_capture[i]) begin
               r_pend[i] <= 1'b1;
               r_dir[i]  <= w_st_next[i];
            end else if (w_clear[i]) begin
               r_pend[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW + 1)'(1);
         else if (!w_push && w_pop) r_count <= r_count - (AW + 1)'(1);
      end
   end

   // NOTE: the event storage has no reset; validity comes only from the reset pointers and count.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= {w_gnt_idx, r_dir[w_gnt_idx]};
   end

   assign w_head     = r_mem[r_rd_ptr];
   assign evt_valid  = (r_count != '0);
   assign evt_chan   = evt_valid ? w_head[CW:1] : '0;
   assign evt_rise   = evt_valid ? w_head[0] : 1'b0;
   assign fifo_count = r_count;
   assign level_out  = r_st;
   assign overflow   = r_overflow;

endmodule
